// File: rtl/execute_stage_if.sv
// Execute-stage bus: E-register operands in, E/M register and forwarding out.
interface execute_stage_if;
  // E register contents
  logic [2:0]  E_stat_i;
  logic [3:0]  E_icode_i;
  logic [3:0]  E_ifun_i;
  logic [63:0] E_valC_i;
  logic [63:0] E_valA_i;
  logic [63:0] E_valB_i;
  logic [63:0] E_valP_i;
  logic [3:0]  E_dstE_i;
  logic [3:0]  E_dstM_i;
  // Downstream status used to suppress CC writes
  logic [2:0]  m_stat_i;
  logic [2:0]  W_stat_i;
  // Combinational forwarding to decode
  logic [63:0] e_valE_o;
  logic [3:0]  e_dstE_o;
  // E/M register
  logic [2:0]  M_stat_o;
  logic [3:0]  M_icode_o;
  logic        M_cnd_o;
  logic [63:0] M_valE_o;
  logic [63:0] M_valA_o;
  logic [63:0] M_valP_o;
  logic [3:0]  M_dstE_o;
  logic [3:0]  M_dstM_o;
  // Condition codes {ZF,SF,OF}
  logic [2:0]  cc_o;

  modport master (
    output E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
           E_valP_i, E_dstE_i, E_dstM_i, m_stat_i, W_stat_i,
    input  e_valE_o, e_dstE_o, M_stat_o, M_icode_o, M_cnd_o, M_valE_o,
           M_valA_o, M_valP_o, M_dstE_o, M_dstM_o, cc_o
  );

  modport slave (
    input  E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
           E_valP_i, E_dstE_i, E_dstM_i, m_stat_i, W_stat_i,
    output e_valE_o, e_dstE_o, M_stat_o, M_icode_o, M_cnd_o, M_valE_o,
           M_valA_o, M_valP_o, M_dstE_o, M_dstM_o, cc_o
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, jXX/cmovXX condition
// evaluation and the E/M pipeline register.
module execute_stage (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic bubble_i,
  execute_stage_if.slave bus
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  localparam logic [3:0] ALUADD  = 4'h0;
  localparam logic [3:0] ALUSUB  = 4'h1;
  localparam logic [3:0] ALUAND  = 4'h2;
  localparam logic [3:0] ALUXOR  = 4'h3;

  // ALU result; unsupported function codes yield zero
  function automatic logic signed [63:0] aluResult(
    input logic [3:0] fun,
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    case (fun)
      ALUADD:  aluResult = b + a;
      ALUSUB:  aluResult = b - a;
      ALUAND:  aluResult = b & a;
      ALUXOR:  aluResult = b ^ a;
      default: aluResult = '0;
    endcase
  endfunction

  // Flags {ZF,SF,OF} produced by an ALU operation
  function automatic logic [2:0] aluFlags(
    input logic [3:0] fun,
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input logic signed [63:0] r
  );
    logic ovf;
    case (fun)
      ALUADD:  ovf = (a[63] == b[63]) && (r[63] != a[63]);
      ALUSUB:  ovf = (a[63] != b[63]) && (r[63] != b[63]);
      default: ovf = 1'b0;
    endcase
    aluFlags = {(r == '0), r[63], ovf};
  endfunction

  // jXX / cmovXX condition from {ZF,SF,OF}
  function automatic logic condEval(input logic [3:0] fun, input logic [2:0] flags);
    logic zf, sf, of;
    {zf, sf, of} = flags;
    case (fun)
      4'd0:    condEval = 1'b1;
      4'd1:    condEval = (sf ^ of) | zf;
      4'd2:    condEval = sf ^ of;
      4'd3:    condEval = zf;
      4'd4:    condEval = ~zf;
      4'd5:    condEval = ~(sf ^ of);
      4'd6:    condEval = ~(sf ^ of) & ~zf;
      default: condEval = 1'b0;
    endcase
  endfunction

  logic signed [63:0] aluA_p0;
  logic signed [63:0] aluB_p0;
  logic        [3:0]  aluFun_p0;
  logic signed [63:0] valE_p0;
  logic        [2:0]  newCc_p0;
  logic               setCc_p0;
  logic               cnd_p0;
  logic        [3:0]  dstE_p0;

  logic        [2:0]  cc_p1;
  logic        [2:0]  mStat_p1;
  logic        [3:0]  mIcode_p1;
  logic               mCnd_p1;
  logic        [63:0] mValE_p1;
  logic        [63:0] mValA_p1;
  logic        [63:0] mValP_p1;
  logic        [3:0]  mDstE_p1;
  logic        [3:0]  mDstM_p1;

  // ---- Stage p0: operand select, ALU, condition evaluation (combinational)

  // Operand A depends on instruction class; stack ops move by one quadword
  always_comb begin
    aluA_p0 = '0;
    case (bus.E_icode_i)
      IRRMOVQ, IOPQ:             aluA_p0 = $signed(bus.E_valA_i);
      IIRMOVQ, IRMMOVQ, IMRMOVQ: aluA_p0 = $signed(bus.E_valC_i);
      ICALL, IPUSHQ:             aluA_p0 = -64'sd8;
      IRET, IPOPQ:               aluA_p0 = 64'sd8;
      default:                   aluA_p0 = '0;
    endcase
  end

  // Operand B is the base register for memory, arithmetic and stack ops
  always_comb begin
    aluB_p0 = '0;
    case (bus.E_icode_i)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ:
        aluB_p0 = $signed(bus.E_valB_i);
      default:
        aluB_p0 = '0;
    endcase
  end

  // ALU, flag generation, condition and effective destination
  always_comb begin
    aluFun_p0 = (bus.E_icode_i == IOPQ) ? bus.E_ifun_i : ALUADD;
    valE_p0   = aluResult(aluFun_p0, aluA_p0, aluB_p0);
    newCc_p0  = aluFlags(aluFun_p0, aluA_p0, aluB_p0, valE_p0);
    setCc_p0  = (bus.E_icode_i == IOPQ) && (bus.E_ifun_i <= ALUXOR) &&
                (bus.m_stat_i == SAOK) && (bus.W_stat_i == SAOK);
    // Uses the CC as it stands before this cycle's possible update
    cnd_p0    = condEval(bus.E_ifun_i, cc_p1);
    dstE_p0   = ((bus.E_icode_i == IRRMOVQ) && !cnd_p0) ? RNONE : bus.E_dstE_i;
  end

  // ---- Stage p1: condition-code register and E/M pipeline register

  // CC: reset to ZF=1; bubble does not block an update, stall does
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cc_p1 <= 3'b100;
    else if (setCc_p0 && !stall_i)
      cc_p1 <= newCc_p0;
  end

  // E/M register: reset and bubble both insert a NOP; stall holds
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      mStat_p1  <= SAOK;
      mIcode_p1 <= INOP;
      mCnd_p1   <= 1'b0;
      mValE_p1  <= '0;
      mValA_p1  <= '0;
      mValP_p1  <= '0;
      mDstE_p1  <= RNONE;
      mDstM_p1  <= RNONE;
    end else if (!stall_i) begin
      mStat_p1  <= bus.E_stat_i;
      mIcode_p1 <= bus.E_icode_i;
      mCnd_p1   <= cnd_p0;
      mValE_p1  <= valE_p0;
      mValA_p1  <= bus.E_valA_i;
      mValP_p1  <= bus.E_valP_i;
      mDstE_p1  <= dstE_p0;
      mDstM_p1  <= bus.E_dstM_i;
    end
  end

  assign bus.e_valE_o  = valE_p0;
  assign bus.e_dstE_o  = dstE_p0;
  assign bus.M_stat_o  = mStat_p1;
  assign bus.M_icode_o = mIcode_p1;
  assign bus.M_cnd_o   = mCnd_p1;
  assign bus.M_valE_o  = mValE_p1;
  assign bus.M_valA_o  = mValA_p1;
  assign bus.M_valP_o  = mValP_p1;
  assign bus.M_dstE_o  = mDstE_p1;
  assign bus.M_dstM_o  = mDstM_p1;
  assign bus.cc_o      = cc_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed steps from the test plan followed by a
// randomized stream, all checked against a behavioural model of the stage.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic bubble = 1'b0;

  execute_stage_if bus ();

  execute_stage dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .stall_i  (stall),
    .bubble_i (bubble),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state (E/M register and CC as seen by the memory stage)
  logic [2:0]  xStat;
  logic [3:0]  xIcode;
  logic        xCnd;
  logic [63:0] xValE, xValA, xValP;
  logic [3:0]  xDstE, xDstM;
  logic        zf, sf, of;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Result of the instruction by its meaning in the ISA
  function automatic logic [63:0] refValE(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    case (ic)
      4'h2:       return a;
      4'h3:       return c;
      4'h4, 4'h5: return b + c;
      4'h6: case (fn)
              4'd0:    return b + a;
              4'd1:    return b - a;
              4'd2:    return b & a;
              4'd3:    return b ^ a;
              default: return 64'd0;
            endcase
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  // Signed overflow judged by whether the true sum fits in 64 bits
  function automatic logic refOf(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] wide;
    if (fn == 4'd0)      wide = $signed({a[63], a}) + $signed({b[63], b});
    else if (fn == 4'd1) wide = $signed({b[63], b}) - $signed({a[63], a});
    else                 return 1'b0;
    return (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
  endfunction

  function automatic logic refCnd(input logic [3:0] fn);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic setE(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [63:0] p,
                      input logic [3:0] dE, input logic [3:0] dM);
    bus.E_icode_i = ic; bus.E_ifun_i = fn;
    bus.E_valA_i = a;   bus.E_valB_i = b; bus.E_valC_i = c; bus.E_valP_i = p;
    bus.E_dstE_i = dE;  bus.E_dstM_i = dM;
    bus.E_stat_i = 3'd1; bus.m_stat_i = 3'd1; bus.W_stat_i = 3'd1;
  endtask

  task automatic randE();
    logic [63:0] pool [4];
    pool[0] = 64'd0; pool[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    pool[2] = 64'h8000_0000_0000_0000; pool[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.E_icode_i = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 2) == 0) bus.E_icode_i = 4'h6;
    bus.E_ifun_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
    bus.E_valA_i = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : {$urandom, $urandom};
    bus.E_valB_i = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : {$urandom, $urandom};
    if ($urandom_range(0, 5) == 0) bus.E_valB_i = bus.E_valA_i;
    bus.E_valC_i = {$urandom, $urandom};
    bus.E_valP_i = {$urandom, $urandom};
    bus.E_dstE_i = 4'($urandom); bus.E_dstM_i = 4'($urandom);
    bus.E_stat_i = 3'($urandom);
    bus.m_stat_i = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd1;
    bus.W_stat_i = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd1;
  endtask

  // One clock: check forwarding, advance the model, check registered state
  task automatic cycle(input string tag);
    logic [63:0] v;
    logic        c;
    logic [3:0]  d;
    #1;
    v = refValE(bus.E_icode_i, bus.E_ifun_i, bus.E_valA_i, bus.E_valB_i, bus.E_valC_i);
    c = refCnd(bus.E_ifun_i);
    d = (bus.E_icode_i == 4'h2 && !c) ? 4'hF : bus.E_dstE_i;
    if (!rst) begin
      chk({tag, ".e_valE"}, bus.e_valE_o, v);
      chk({tag, ".e_dstE"}, {60'd0, bus.e_dstE_o}, {60'd0, d});
    end
    if (rst) begin
      {zf, sf, of} = 3'b100;
    end else if (bus.E_icode_i == 4'h6 && bus.E_ifun_i <= 4'd3 && bus.m_stat_i == 3'd1 &&
                 bus.W_stat_i == 3'd1 && !stall) begin
      zf = (v == 64'd0);
      sf = v[63];
      of = refOf(bus.E_ifun_i, bus.E_valA_i, bus.E_valB_i);
    end
    if (rst || bubble) begin
      xStat = 3'd1; xIcode = 4'h1; xCnd = 1'b0; xValE = '0; xValA = '0; xValP = '0;
      xDstE = 4'hF; xDstM = 4'hF;
    end else if (!stall) begin
      xStat = bus.E_stat_i; xIcode = bus.E_icode_i; xCnd = c; xValE = v;
      xValA = bus.E_valA_i; xValP = bus.E_valP_i; xDstE = d; xDstM = bus.E_dstM_i;
    end
    @(negedge clk);
    chk({tag, ".M_stat"},  {61'd0, bus.M_stat_o},  {61'd0, xStat});
    chk({tag, ".M_icode"}, {60'd0, bus.M_icode_o}, {60'd0, xIcode});
    chk({tag, ".M_cnd"},   {63'd0, bus.M_cnd_o},   {63'd0, xCnd});
    chk({tag, ".M_valE"},  bus.M_valE_o, xValE);
    chk({tag, ".M_valA"},  bus.M_valA_o, xValA);
    chk({tag, ".M_valP"},  bus.M_valP_o, xValP);
    chk({tag, ".M_dstE"},  {60'd0, bus.M_dstE_o},  {60'd0, xDstE});
    chk({tag, ".M_dstM"},  {60'd0, bus.M_dstM_o},  {60'd0, xDstM});
    chk({tag, ".cc"},      {61'd0, bus.cc_o},      {61'd0, zf, sf, of});
  endtask

  initial begin
    logic [63:0] frzValE;
    logic [2:0]  frzCc;
    logic [3:0]  frzIcode;
    {zf, sf, of} = 3'b100;
    randE();
    @(negedge clk);

    // Reset held two cycles with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randE();
      stall = 1'($urandom); bubble = 1'($urandom);
      cycle("reset");
    end
    chk("reset.icode", {60'd0, bus.M_icode_o}, 64'd1);
    chk("reset.dstE",  {60'd0, bus.M_dstE_o},  64'hF);
    chk("reset.valE",  bus.M_valE_o, 64'd0);
    chk("reset.cc",    {61'd0, bus.cc_o}, 64'b100);
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;

    // OPQ SUB 3-5
    setE(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'd0, 4'h3, 4'hF);
    #1 chk("sub.e_valE", bus.e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle("sub");
    chk("sub.M_valE", bus.M_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub.cc", {61'd0, bus.cc_o}, 64'b010);

    // ADD overflow
    setE(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'h2, 4'hF);
    cycle("addovf");
    chk("addovf.M_valE", bus.M_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("addovf.cc", {61'd0, bus.cc_o}, 64'b011);

    // cmovl with SF=OF=1: not taken
    setE(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 64'd0, 4'h5, 4'hF);
    cycle("cmovl");
    chk("cmovl.cnd",  {63'd0, bus.M_cnd_o}, 64'd0);
    chk("cmovl.dstE", {60'd0, bus.M_dstE_o}, 64'hF);

    // Stack ops
    setE(4'hA, 4'h0, 64'hAAAA, 64'h100, 64'd0, 64'd0, 4'h4, 4'hF);
    cycle("pushq");
    chk("pushq.valE", bus.M_valE_o, 64'hF8);
    setE(4'hB, 4'h0, 64'hBEEF, 64'h100, 64'd0, 64'd0, 4'h4, 4'h3);
    cycle("popq");
    chk("popq.valE", bus.M_valE_o, 64'h108);
    chk("popq.valA", bus.M_valA_o, 64'hBEEF);
    setE(4'h8, 4'h0, 64'd0, 64'h100, 64'h40, 64'h2, 4'h4, 4'hF);
    cycle("call");
    chk("call.valE", bus.M_valE_o, 64'hF8);
    chk("call.valP", bus.M_valP_o, 64'h2);

    // CC write suppressed by a faulting downstream instruction
    setE(4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 64'd0, 4'h1, 4'hF);
    bus.m_stat_i = 3'd2;
    cycle("xorsadr");
    chk("xorsadr.valE", bus.M_valE_o, 64'd0);
    chk("xorsadr.cc", {61'd0, bus.cc_o}, 64'b011);
    bus.m_stat_i = 3'd1;
    cycle("xoraok");
    chk("xoraok.cc", {61'd0, bus.cc_o}, 64'b100);

    // Stall three cycles with changing inputs
    frzValE = bus.M_valE_o; frzCc = bus.cc_o; frzIcode = bus.M_icode_o;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randE();
      bus.E_icode_i = 4'h6; bus.E_ifun_i = 4'h1; bus.m_stat_i = 3'd1; bus.W_stat_i = 3'd1;
      cycle("stall");
    end
    chk("stall.valE",  bus.M_valE_o, frzValE);
    chk("stall.cc",    {61'd0, bus.cc_o}, {61'd0, frzCc});
    chk("stall.icode", {60'd0, bus.M_icode_o}, {60'd0, frzIcode});

    // Bubble wins over stall
    bubble = 1'b1;
    randE();
    cycle("stallbub");
    chk("stallbub.icode", {60'd0, bus.M_icode_o}, 64'd1);
    stall = 1'b0; bubble = 1'b0;

    // Randomized stream with occasional stall, bubble and reset
    for (int i = 0; i < 400; i++) begin
      randE();
      stall  = ($urandom_range(0, 7) == 0);
      bubble = ($urandom_range(0, 9) == 0);
      rst    = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
